// File: rtl/led_breathe.sv
// LED breathing envelope: a triangle brightness ramp with dwell at both extremes, driving a registered PWM LED.
// Optional macro LED_BREATHE_GAMMA_EN squares the compare value for perceptually even dimming.
module led_breathe #(
    parameter int PWM_W      = 8,
    parameter int STEP       = 4,
    parameter int HOLD_TICKS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             en,
    output logic             WF_LED,
    output logic [PWM_W-1:0] level,
    output logic [1:0]       state
);

    localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

    localparam logic [1:0] ST_UP      = 2'd0;
    localparam logic [1:0] ST_HOLD_HI = 2'd1;
    localparam logic [1:0] ST_DOWN    = 2'd2;
    localparam logic [1:0] ST_HOLD_LO = 2'd3;

    localparam logic [PWM_W-1:0] MAX       = {PWM_W{1'b1}};
    localparam logic [PWM_W-1:0] STEP_V    = PWM_W'(STEP);
    localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD_TICKS - 1);

    logic [PWM_W-1:0] pwm_cnt;
    logic [PWM_W-1:0] cmp;
    logic [HW-1:0]    hold_cnt;
    logic [PWM_W:0]   up_sum;
    logic             advance;

    assign advance = tick & en;
    // One extra bit so the ramp top is detected without wrapping back to a dim level.
    assign up_sum  = {1'b0, level} + {1'b0, STEP_V};

`ifdef LED_BREATHE_GAMMA_EN
    logic [2*PWM_W-1:0] level_sq;
    assign level_sq = level * level;
    assign cmp      = level_sq[2*PWM_W-1:PWM_W];
`else
    assign cmp = level;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            WF_LED <= 1'b0;
        end else begin
            WF_LED <= en && (cmp > pwm_cnt);
        end
    end

    // Envelope only moves on a qualified tick; everything else freezes it in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            level    <= '0;
            state    <= ST_HOLD_LO;
            hold_cnt <= '0;
        end else if (advance) begin
            case (state)
                ST_UP: begin
                    if (up_sum >= {1'b0, MAX}) begin
                        level    <= MAX;
                        state    <= ST_HOLD_HI;
                        hold_cnt <= '0;
                    end else begin
                        level <= up_sum[PWM_W-1:0];
                    end
                end
                ST_HOLD_HI: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state    <= ST_DOWN;
                        hold_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                ST_DOWN: begin
                    if (level <= STEP_V) begin
                        level    <= '0;
                        state    <= ST_HOLD_LO;
                        hold_cnt <= '0;
                    end else begin
                        level <= level - STEP_V;
                    end
                end
                default: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state    <= ST_UP;
                        hold_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_breathe.sv
// Scoreboard bench for led_breathe: a spec-level envelope model predicts each cycle, a monitor compares.
// Works with or without LED_BREATHE_GAMMA_EN defined.
module tb_led_breathe;

    localparam int PWM_W      = 8;
    localparam int STEP       = 4;
    localparam int HOLD_TICKS = 16;
    localparam int MAX        = (1 << PWM_W) - 1;
    localparam int PERIOD     = 1 << PWM_W;

    logic             clk  = 1'b0;
    logic             rst  = 1'b1;
    logic             tick = 1'b0;
    logic             en   = 1'b0;
    logic             WF_LED;
    logic [PWM_W-1:0] level;
    logic [1:0]       state;

    typedef struct packed {
        logic [7:0] level;
        logic [1:0] state;
        logic       led;
        logic [3:0] hold;
    } exp_t;

    exp_t exp_q[$];

    int vectors     = 0;
    int miscompares = 0;

    // Model of the envelope as the spec describes it: a level in 0..MAX, a phase, and a dwell count.
    int m_level = 0;
    int m_phase = 3;
    int m_hold  = 0;
    int m_pwm   = 0;

    led_breathe #(
        .PWM_W     (PWM_W),
        .STEP      (STEP),
        .HOLD_TICKS(HOLD_TICKS)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .tick  (tick),
        .en    (en),
        .WF_LED(WF_LED),
        .level (level),
        .state (state)
    );

    always #5 clk = ~clk;

    function automatic int cmp_of(input int l);
`ifdef LED_BREATHE_GAMMA_EN
        return (l * l) / PERIOD;
`else
        return l;
`endif
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic t, input logic e);
        exp_t x;
        int   led_n;
        rst  = r;
        tick = t;
        en   = e;
        led_n = (!r && e && (cmp_of(m_level) > m_pwm)) ? 1 : 0;
        if (r) begin
            m_level = 0;
            m_phase = 3;
            m_hold  = 0;
            m_pwm   = 0;
        end else begin
            m_pwm = (m_pwm + 1) % PERIOD;
            if (t && e) begin
                if (m_phase == 0) begin
                    m_level = (m_level + STEP >= MAX) ? MAX : m_level + STEP;
                    if (m_level == MAX) begin
                        m_phase = 1;
                        m_hold  = 0;
                    end
                end else if (m_phase == 2) begin
                    m_level = (m_level <= STEP) ? 0 : m_level - STEP;
                    if (m_level == 0) begin
                        m_phase = 3;
                        m_hold  = 0;
                    end
                end else if (m_hold == HOLD_TICKS - 1) begin
                    m_phase = (m_phase == 1) ? 2 : 0;
                    m_hold  = 0;
                end else begin
                    m_hold = m_hold + 1;
                end
            end
        end
        x.level = 8'(m_level);
        x.state = 2'(m_phase);
        x.led   = 1'(led_n);
        x.hold  = 4'(m_hold);
        exp_q.push_back(x);
        @(negedge clk);
    endtask

    task automatic runTicks(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, 1'b1);
    endtask

    task automatic runDuty(input int cycles, output int highs);
        highs = 0;
        for (int i = 0; i < cycles; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            if (WF_LED) highs++;
        end
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                checkOutput("level", int'(level), int'(x.level));
                checkOutput("state", int'(state), int'(x.state));
                checkOutput("wf_led", int'(WF_LED), int'(x.led));
                checkOutput("hold_cnt", int'(dut.hold_cnt), int'(x.hold));
            end
        end
    end

    initial begin : stimulus
        int highs;
        @(negedge clk);

        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'($urandom % 2), 1'($urandom % 2));
        checkOutput("reset_level", int'(level), 0);
        checkOutput("reset_state", int'(state), 3);
        checkOutput("reset_led", int'(WF_LED), 0);

        runTicks(16);
        checkOutput("hold_lo_exit_state", int'(state), 0);
        runTicks(63);
        checkOutput("up_63_level", int'(level), 252);
        runTicks(1);
        checkOutput("up_top_level", int'(level), 255);
        checkOutput("up_top_state", int'(state), 1);
        runTicks(16);
        checkOutput("hold_hi_exit_state", int'(state), 2);
        runTicks(63);
        checkOutput("down_63_level", int'(level), 3);
        runTicks(1);
        checkOutput("down_bottom_level", int'(level), 0);
        checkOutput("down_bottom_state", int'(state), 3);

        runTicks(16 + 32);
        checkOutput("ramp_128_level", int'(level), 128);
        runDuty(PERIOD, highs);
        checkOutput("duty_128", highs, cmp_of(128));

        applyStimulus(1'b1, 1'b0, 1'b0);
        runDuty(PERIOD, highs);
        checkOutput("duty_0", highs, 0);

        runTicks(16 + 64);
        checkOutput("ramp_max_level", int'(level), MAX);
        runDuty(PERIOD, highs);
        checkOutput("duty_max", highs, cmp_of(MAX));

        applyStimulus(1'b1, 1'b0, 1'b0);
        runTicks(16 + 25);
        checkOutput("freeze_pre_level", int'(level), 100);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("freeze_led_next", int'(WF_LED), 0);
        checkOutput("freeze_level_next", int'(level), 100);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("freeze_level_held", int'(level), 100);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("resume_level", int'(level), 104);

        applyStimulus(1'b1, 1'b0, 1'b0);
        runTicks(16 + 64 + 16 + 14);
        checkOutput("down_mid_level", int'(level), 199);
        checkOutput("down_mid_state", int'(state), 2);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("midramp_rst_level", int'(level), 0);
        checkOutput("midramp_rst_state", int'(state), 3);
        checkOutput("midramp_rst_led", int'(WF_LED), 0);
        checkOutput("midramp_rst_hold", int'(dut.hold_cnt), 0);

        for (int i = 0; i < 2000; i++) begin
            applyStimulus(1'($urandom_range(0, 99) == 0), 1'($urandom % 2),
                          1'($urandom_range(0, 99) < 85));
        end

        @(posedge clk);
        #3;
        checkOutput("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
